// File: rtl/bullet_pool_renderer.sv
// Projectile pool: spawns fire requests into free slots, moves live slots once per
// frame, retires them at the screen edge or on a hit, and renders a 4x4 sprite per slot.
module bullet_pool_renderer #(
    parameter int NUM_BULLETS = 10,
    parameter int SPEED       = 4,
    parameter int SCREEN_W    = 640
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               frame_clk,
    input  logic [9:0]                         DrawX,
    input  logic [9:0]                         DrawY,
    // Fire handshake: a request is accepted on any edge where fire_valid && fire_ready;
    // fire_ready only depends on pool occupancy, and an unaccepted request is simply dropped
    // for that cycle (the requester keeps fire_valid high until it sees acceptance).
    input  logic                               fire_valid,
    output logic                               fire_ready,
    input  logic [9:0]                         fire_x,
    input  logic [9:0]                         fire_y,
    input  logic                               fire_dir,
    input  logic [NUM_BULLETS-1:0]             hit_clear,
    output logic [NUM_BULLETS-1:0]             active,
    output logic [$clog2(NUM_BULLETS+1)-1:0]   active_count,
    output logic [NUM_BULLETS-1:0]             is_bullet,
    output logic [4*NUM_BULLETS-1:0]           bullet_data
);

    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CW = $clog2(NUM_BULLETS+1);

    logic [9:0]             x_q [NUM_BULLETS];
    logic [9:0]             y_q [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] dir_q;
    logic                   frame_clk_q;
    logic                   frame_tick;

    logic                   spawn_en;
    logic [IW-1:0]          spawn_idx;
    logic [NUM_BULLETS-1:0] expire;
    logic [NUM_BULLETS-1:0] move_en;
    logic [NUM_BULLETS-1:0] active_nxt;
    logic [CW-1:0]          count_nxt;
    logic [NUM_BULLETS-1:0]   hit_nxt;
    logic [4*NUM_BULLETS-1:0] data_nxt;

    function automatic logic [3:0] sprite_rom(input logic [1:0] r, input logic [1:0] c);
        logic edge_r;
        logic edge_c;
        edge_r = (r == 2'd0) || (r == 2'd3);
        edge_c = (c == 2'd0) || (c == 2'd3);
        if (edge_r) sprite_rom = edge_c ? 4'd0 : 4'd3;
        else        sprite_rom = edge_c ? 4'd3 : 4'd7;
    endfunction

    assign fire_ready = |(~active);
    assign frame_tick = frame_clk & ~frame_clk_q;

    always_comb begin
        spawn_en   = 1'b0;
        spawn_idx  = '0;
        expire     = '0;
        move_en    = '0;
        active_nxt = active;
        count_nxt  = '0;
        // Descending scan so the lowest free index wins.
        for (int i = NUM_BULLETS-1; i >= 0; i--) begin
            if (!active[i]) begin
                spawn_en  = fire_valid;
                spawn_idx = IW'(i);
            end
        end
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (dir_q[i]) expire[i] = {1'b0, x_q[i]} < 11'(SPEED);
            else          expire[i] = ({1'b0, x_q[i]} + 11'(SPEED)) > 11'(SCREEN_W - 4);
            if (active[i]) begin
                if (hit_clear[i])                 active_nxt[i] = 1'b0;
                else if (frame_tick && expire[i]) active_nxt[i] = 1'b0;
                else                              move_en[i]    = frame_tick;
            end else if (spawn_en && spawn_idx == IW'(i)) begin
                active_nxt[i] = 1'b1;
            end
            count_nxt = count_nxt + CW'(active_nxt[i]);
        end
    end

    always_comb begin
        hit_nxt  = '0;
        data_nxt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_nxt[i] = active[i]
                && ({1'b0, DrawX} >= {1'b0, x_q[i]}) && ({1'b0, DrawX} <= {1'b0, x_q[i]} + 11'd3)
                && ({1'b0, DrawY} >= {1'b0, y_q[i]}) && ({1'b0, DrawY} <= {1'b0, y_q[i]} + 11'd3);
            if (hit_nxt[i])
                data_nxt[4*i +: 4] = sprite_rom(DrawY[1:0] - y_q[i][1:0], DrawX[1:0] - x_q[i][1:0]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q  <= 1'b0;
            active       <= '0;
            active_count <= '0;
            dir_q        <= '0;
            is_bullet    <= '0;
            bullet_data  <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            frame_clk_q  <= frame_clk;
            active       <= active_nxt;
            active_count <= count_nxt;
            is_bullet    <= hit_nxt;
            bullet_data  <= data_nxt;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (move_en[i]) begin
                    x_q[i] <= dir_q[i] ? x_q[i] - 10'(SPEED) : x_q[i] + 10'(SPEED);
                end else if (!active[i] && spawn_en && spawn_idx == IW'(i)) begin
                    // A fresh spawn takes fire_x unmoved even on a frame tick.
                    x_q[i]   <= fire_x;
                    y_q[i]   <= fire_y;
                    dir_q[i] <= fire_dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool_renderer.sv
// Directed bench for bullet_pool_renderer: spawn, render, motion, expiry, pool fill,
// same-cycle interactions and asynchronous reset.
module tb_bullet_pool_renderer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        fire_valid = 1'b0;
    logic        fire_ready;
    logic [9:0]  fire_x = '0;
    logic [9:0]  fire_y = '0;
    logic        fire_dir = 1'b0;
    logic [9:0]  hit_clear = '0;
    logic [9:0]  active;
    logic [3:0]  active_count;
    logic [9:0]  is_bullet;
    logic [39:0] bullet_data;

    int tests = 0;
    int fails = 0;

    bullet_pool_renderer #(.NUM_BULLETS(10), .SPEED(4), .SCREEN_W(640)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY),
        .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir),
        .hit_clear(hit_clear), .active(active), .active_count(active_count),
        .is_bullet(is_bullet), .bullet_data(bullet_data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fire(input logic [9:0] fx, input logic [9:0] fy, input logic fd);
        fire_valid = 1'b1; fire_x = fx; fire_y = fy; fire_dir = fd;
        tick();
        fire_valid = 1'b0;
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py);
        DrawX = px; DrawY = py;
        tick();
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (5) tick();
        frame_clk = 1'b0;
        repeat (2) tick();
    endtask

    task automatic clear(input logic [9:0] mask);
        hit_clear = mask;
        tick();
        hit_clear = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_active", active, 10'h000);
        check("rst_count", active_count, 4'd0);
        check("rst_is_bullet", is_bullet, 10'h000);
        check("rst_data", bullet_data, 40'h0);
        check("rst_fire_ready", fire_ready, 1'b1);
        Reset = 1'b0;
        tick();

        // Spawn and render
        fire(10'd100, 10'd200, 1'b0);
        check("spawn_active", active, 10'h001);
        check("spawn_count", active_count, 4'd1);
        probe(10'd101, 10'd201);
        check("pix_inner_hit", is_bullet, 10'h001);
        check("pix_inner_data", bullet_data, 40'h7);
        probe(10'd100, 10'd200);
        check("pix_corner_hit", is_bullet, 10'h001);
        check("pix_corner_data", bullet_data, 40'h0);
        probe(10'd104, 10'd200);
        check("pix_right_miss", is_bullet, 10'h000);
        probe(10'd103, 10'd204);
        check("pix_below_miss", is_bullet, 10'h000);

        // Three frames: x 100 -> 112, held frame_clk gives no extra moves
        repeat (3) frame_pulse();
        probe(10'd113, 10'd200);
        check("move_edge_hit", is_bullet, 10'h001);
        check("move_edge_data", bullet_data, 40'h3);
        probe(10'd111, 10'd200);
        check("move_left_miss", is_bullet, 10'h000);
        probe(10'd115, 10'd202);
        check("move_far_col", bullet_data, 40'h3);
        clear(10'h001);
        check("hit_retire", active, 10'h000);

        // Right expiry: 630 -> 634 stays, 638 > 636 retires
        fire(10'd630, 10'd10, 1'b0);
        frame_pulse();
        check("rexp_tick1", active, 10'h001);
        probe(10'd634, 10'd10);
        check("rexp_pos", is_bullet, 10'h001);
        frame_pulse();
        check("rexp_tick2", active, 10'h000);
        check("rexp_count", active_count, 4'd0);

        // Left expiry: 3 < 4 retires; 4 moves to 0 then retires
        fire(10'd3, 10'd20, 1'b1);
        frame_pulse();
        check("lexp_3", active, 10'h000);
        fire(10'd4, 10'd20, 1'b1);
        frame_pulse();
        check("lexp_4_alive", active, 10'h001);
        probe(10'd0, 10'd20);
        check("lexp_4_at0", is_bullet, 10'h001);
        frame_pulse();
        check("lexp_0_retire", active, 10'h000);

        // Fill pool, overflow ignored, refill freed slot
        for (int i = 0; i < 10; i++) fire(10'(i * 20), 10'd100, 1'b0);
        check("fill_active", active, 10'h3FF);
        check("fill_count", active_count, 4'd10);
        check("fill_ready", fire_ready, 1'b0);
        fire(10'd500, 10'd300, 1'b0);
        check("ovf_active", active, 10'h3FF);
        probe(10'd500, 10'd300);
        check("ovf_no_sprite", is_bullet, 10'h000);
        clear(10'h010);
        check("free4_active", active, 10'h3EF);
        check("free4_count", active_count, 4'd9);
        check("free4_ready", fire_ready, 1'b1);
        fire(10'd300, 10'd400, 1'b0);
        check("refill_active", active, 10'h3FF);
        probe(10'd301, 10'd401);
        check("refill_slot4", is_bullet, 10'h010);
        check("refill_data", bullet_data, 40'h0_0007_0000);
        clear(10'h3FF);
        check("clear_all", active_count, 4'd0);

        // Spawn in the tick cycle: slot0 moves, slot1 keeps fire_x
        fire(10'd100, 10'd200, 1'b0);
        frame_clk = 1'b1;
        fire(10'd50, 10'd60, 1'b0);
        check("sim_active", active, 10'h003);
        check("sim_count", active_count, 4'd2);
        repeat (4) tick();
        frame_clk = 1'b0;
        repeat (2) tick();
        probe(10'd104, 10'd200);
        check("sim_slot0_moved", is_bullet, 10'h001);
        probe(10'd103, 10'd200);
        check("sim_slot0_left", is_bullet, 10'h000);
        probe(10'd50, 10'd60);
        check("sim_slot1_unmoved", is_bullet, 10'h002);

        // hit_clear coinciding with a tick
        frame_clk = 1'b1;
        hit_clear = 10'h001;
        tick();
        hit_clear = '0;
        check("hit_tick_active", active, 10'h002);
        check("hit_tick_count", active_count, 4'd1);
        repeat (4) tick();
        frame_clk = 1'b0;
        repeat (2) tick();
        probe(10'd54, 10'd60);
        check("slot1_moved", is_bullet, 10'h002);
        clear(10'h004);
        check("hit_inactive", active, 10'h002);

        // Asynchronous reset with five slots live
        fire(10'd10, 10'd10, 1'b0);
        fire(10'd200, 10'd10, 1'b0);
        fire(10'd300, 10'd10, 1'b0);
        fire(10'd400, 10'd10, 1'b0);
        check("pre_rst_count", active_count, 4'd5);
        probe(10'd11, 10'd11);
        check("pre_rst_data", bullet_data, 40'h7);
        #3;
        Reset = 1'b1;
        #1;
        check("arst_active", active, 10'h000);
        check("arst_is_bullet", is_bullet, 10'h000);
        check("arst_data", bullet_data, 40'h0);
        check("arst_count", active_count, 4'd0);
        check("arst_ready", fire_ready, 1'b1);
        tick();
        Reset = 1'b0;
        tick();
        check("post_rst_is_bullet", is_bullet, 10'h000);
        check("post_rst_ready", fire_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bullet_pool_renderer.md
Name: bullet_pool_renderer

Overview:
- Owns the projectile pool and produces the per-pixel is_bullet flags and 4-bit palette indices that the VGA colour mapper consumes.
- Accepts fire requests from the player-control logic and stores up to NUM_BULLETS projectiles.
- Moves every live projectile once per frame and retires it at the screen edge or on a hit.
- For each DrawX/DrawY from the VGA controller, reports which slots cover that pixel and which sprite colour index each one shows.

Parameters:
NUM_BULLETS, 10, number of projectile slots
SPEED, 4, horizontal pixels moved per frame
SCREEN_W, 640, visible width in pixels

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  vsync-derived frame signal; rising edge detected internally
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
fire_valid  in  1  fire request
fire_ready  out  1  a free slot exists
fire_x  in  10  spawn column, sprite top-left
fire_y  in  10  spawn row, sprite top-left
fire_dir  in  1  0 = moving right, 1 = moving left
hit_clear  in  NUM_BULLETS  one-cycle pulse per slot; retires that slot
active  out  NUM_BULLETS  slot-live flags
active_count  out  $clog2(NUM_BULLETS+1)  number of live slots
is_bullet  out  NUM_BULLETS  slot i covers the pixel (DrawX,DrawY) from the previous cycle
bullet_data  out  4*NUM_BULLETS  slot i palette index in bits [4i+3:4i]

Behaviour:
- Reset: asynchronous and active-high. All slots clear, with x, y and dir set to 0. frame_clk history register cleared. active, active_count, is_bullet and bullet_data are all 0.
- fire_ready is combinational: fire_ready = |~active. It reads 1 while Reset is asserted.
- Frame tick: frame_tick = frame_clk & ~frame_clk_q. It is a one-cycle pulse, so one tick per frame.
- Spawn (when fire_valid && fire_ready):
  - The lowest-index inactive slot loads fire_x, fire_y and fire_dir, and sets active on the next edge.
  - At most one spawn per cycle. fire_valid while fire_ready=0 is ignored, with no queueing; the requester holds valid.
- Motion on frame_tick, for every slot that was active before this edge (evaluated in 11-bit arithmetic):
  - dir=0: if x + SPEED > SCREEN_W - 4, the slot is deactivated; otherwise x <= x + SPEED.
  - dir=1: if x < SPEED, the slot is deactivated; otherwise x <= x - SPEED.
  - y never changes.
- Priority per slot, highest first: hit_clear, then motion/expiry, then hold.
- Spawn targets only slots inactive before the edge. A slot retired by hit_clear or expiry in cycle N is spawnable from cycle N+1.
- Spawn and frame_tick in the same cycle: the new slot takes fire_x unmoved. Existing slots move normally.
- hit_clear on an inactive slot has no effect.
- active_count is registered and consistent with active in the same cycle.
- Sprite: fixed 4x4 ROM, addressed as row r = DrawY - y and column c = DrawX - x:
  - row0: 0 3 3 0
  - row1: 3 7 7 3
  - row2: 3 7 7 3
  - row3: 0 3 3 0
  - Index 0 is the transparent mask colour.
- Pixel output: registered, exactly 1 cycle after DrawX/DrawY.
  - is_bullet[i] = active[i] && x ≤ DrawX ≤ x+3 && y ≤ DrawY ≤ y+3, using the slot state at sampling time.
  - bullet_data[i] = ROM[r][c] when is_bullet[i] is 1, else 0.
  - is_bullet stays 1 on transparent corners. Masking is done by the colour mapper.
- Coordinate arithmetic uses 11 bits, so x+3 and y+3 never wrap. Sprites partly beyond SCREEN_W or the bottom are simply clipped by DrawX/DrawY range.
- Reset mid-flight: all slots vanish immediately (asynchronous). is_bullet is 0 and fire_ready is 1 on the first cycle after release.

Test Plan:
- Reset, then fire (100,200,dir0) → slot0 active next cycle, active_count=1. Drive DrawX=101, DrawY=201 → one cycle later is_bullet[0]=1, bullet_data[3:0]=7. Drive (100,200) → is_bullet[0]=1, data=0. Drive (104,200) → is_bullet[0]=0.
- Three frame_clk rising edges (frame_clk held high 5 cycles each) → slot0 x=112. Pixel (113,200) → data 3. Holding frame_clk high produces no extra moves.
- Right expiry: fire x=630 dir0 → tick 1 gives x=634, still active. Tick 2 (638 > 636) → active[0]=0, active_count=0. Left expiry: fire x=3 dir1 → one tick → deactivated.
- Fill: 10 consecutive accepted fires → slots 0–9 active, fire_ready=0. 11th fire_valid is ignored. Pulse hit_clear[4] → next cycle fire_ready=1, next fire lands in slot 4.
- Simultaneous: slot0 at x=100 dir0, fire (50,60) in the frame_tick cycle → slot0 x=104, slot1 x=50. A hit_clear[0] coinciding with a tick retires slot0 with no move.
- Assert Reset asynchronously with 5 slots live → active=0, is_bullet=0 and bullet_data=0 without waiting for a clock edge.
